// File: rtl/mx_pkg.sv
// ---------------------------------------------------------------------------
// mx_pkg
// Shared definitions for the mx shift/round datapath.
//   MODE_W     : width of the rounding-mode field
//   rnd_mode_e : rounding modes; encoding 2'b11 is unnamed and is handled
//                as round-to-nearest-even by its users
// ---------------------------------------------------------------------------
package mx_pkg;

  localparam int MODE_W = 2;

  typedef enum logic [MODE_W-1:0] {
    RND_RNE   = 2'b00,
    RND_RTZ   = 2'b01,
    RND_FLOOR = 2'b10
  } rnd_mode_e;

endpackage

// File: rtl/shift_rnd_lane.sv
// ---------------------------------------------------------------------------
// shift_rnd_lane
// One lane of the shift-and-round datapath, two register stages.
//   Stage 1 : arithmetic right shift by s = shift + (WIDTH_I - WIDTH_O),
//             capture truncated quotient and guard/round/sticky bits.
//   Stage 2 : apply the rounding increment, detect overflow and produce
//             the WIDTH_O-bit result.
// Ports
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : capture num/shift/mode into stage 1
//   advance    : move stage 1 into stage 2 (output registers)
//   num        : signed input element
//   shift      : extra right shift (unsigned)
//   mode       : rounding mode (rnd_mode_e encoding, 2'b11 acts as RNE)
//   rnd        : rounded result
//   ofl        : rounded value did not fit in WIDTH_O bits
// Build option
//   MX_SHIFT_RND_SAT_EN : overflowing results saturate instead of wrapping.
// ---------------------------------------------------------------------------
module shift_rnd_lane
  import mx_pkg::*;
#(
  parameter int WIDTH_I     = 9,
  parameter int WIDTH_O     = 8,
  parameter int WIDTH_SHIFT = $clog2(WIDTH_I + 2)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       load,
  input  logic                       advance,
  input  logic signed [WIDTH_I-1:0]  num,
  input  logic [WIDTH_SHIFT-1:0]     shift,
  input  logic [MODE_W-1:0]          mode,
  output logic [WIDTH_O-1:0]         rnd,
  output logic                       ofl
);

  localparam int BASE = WIDTH_I - WIDTH_O;
  localparam int SMAX = (1 << WIDTH_SHIFT) - 1 + BASE;
  // Extended operand is a power of two wide so any s, and the quotient
  // window starting at s, index it without running off the top.
  localparam int SW   = $clog2(SMAX + WIDTH_I + 1);
  localparam int EW   = 1 << SW;

  localparam logic signed [WIDTH_I:0] MAX_V = (WIDTH_I+1)'((2 ** (WIDTH_O - 1)) - 1);
  localparam logic signed [WIDTH_I:0] MIN_V = ~MAX_V;
`ifdef MX_SHIFT_RND_SAT_EN
  localparam logic [WIDTH_O-1:0] MAX_O = {1'b0, {(WIDTH_O-1){1'b1}}};
  localparam logic [WIDTH_O-1:0] MIN_O = {1'b1, {(WIDTH_O-1){1'b0}}};
`endif

  logic [SW-1:0]         s_amt;
  logic [EW-1:0]         ext;
  logic [EW-1:0]         sticky_mask;
  logic [WIDTH_I-1:0]    quo;
  logic                  grd;
  logic                  rbit;
  logic                  sticky;

  logic [WIDTH_I-1:0]    q1;
  logic                  g1;
  logic                  r1;
  logic                  st1;
  logic [MODE_W-1:0]     mode1;

  logic signed [WIDTH_I:0] qx;
  logic signed [WIDTH_I:0] res;
  logic                    inc;
  logic                    ofl_c;
  logic [WIDTH_O-1:0]      rnd_c;

  // Sign-extending the operand far enough makes every bit position at or
  // above WIDTH_I read as the sign, so the quotient window, guard, round
  // and sticky all fall out of plain indexing. s is always at least 1.
  always_comb begin
    s_amt       = SW'(shift) + SW'(BASE);
    ext         = {{(EW-WIDTH_I){num[WIDTH_I-1]}}, num};
    quo         = ext[s_amt +: WIDTH_I];
    grd         = ext[s_amt - SW'(1)];
    rbit        = 1'b0;
    sticky_mask = '0;
    if (s_amt >= SW'(2)) begin
      rbit = ext[s_amt - SW'(2)];
    end
    if (s_amt >= SW'(3)) begin
      sticky_mask = ~({EW{1'b1}} << (s_amt - SW'(2)));
    end
    sticky = |(ext & sticky_mask);
  end

  // Stage 1 holds the floor quotient plus the bits needed to round it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q1    <= '0;
      g1    <= 1'b0;
      r1    <= 1'b0;
      st1   <= 1'b0;
      mode1 <= '0;
    end else if (load) begin
      q1    <= quo;
      g1    <= grd;
      r1    <= rbit;
      st1   <= sticky;
      mode1 <= mode;
    end
  end

  // The quotient is a floor, so toward-zero only bumps negative values
  // with a non-zero remainder and floor never bumps.
  always_comb begin
    qx = {q1[WIDTH_I-1], q1};
    case (mode1)
      RND_RTZ:   inc = q1[WIDTH_I-1] & (g1 | r1 | st1);
      RND_FLOOR: inc = 1'b0;
      default:   inc = g1 & (r1 | st1 | q1[0]);
    endcase
    res   = qx + (WIDTH_I+1)'(inc);
    ofl_c = (res > MAX_V) || (res < MIN_V);
`ifdef MX_SHIFT_RND_SAT_EN
    if (ofl_c) begin
      rnd_c = res[WIDTH_I] ? MIN_O : MAX_O;
    end else begin
      rnd_c = res[WIDTH_O-1:0];
    end
`else
    rnd_c = res[WIDTH_O-1:0];
`endif
  end

  // Stage 2 is the output register of the lane.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rnd <= '0;
      ofl <= 1'b0;
    end else if (advance) begin
      rnd <= rnd_c;
      ofl <= ofl_c;
    end
  end

endmodule

// File: rtl/mx_shift_rnd_lanes.sv
// ---------------------------------------------------------------------------
// mx_shift_rnd_lanes
// LANES parallel signed shift-and-round lanes sharing one shift amount and
// rounding mode, behind a two-stage valid/ready pipeline, with a saturating
// count of output beats that carried any overflow.
// Ports
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_valid/o_ready: input handshake
//   i_num          : LANES packed signed WIDTH_I elements, lane 0 in LSBs
//   i_shift        : extra right shift beyond WIDTH_I-WIDTH_O
//   i_mode         : 00 RNE, 01 toward zero, 10 floor, 11 RNE
//   o_valid/i_ready: output handshake
//   o_rnd          : LANES packed WIDTH_O results
//   o_ofl          : per-lane overflow of the current output beat
//   i_cnt_clr      : synchronous clear of o_ofl_cnt
//   o_ofl_cnt      : saturating count of transferred beats with any overflow
// Build option
//   MX_SHIFT_RND_SAT_EN : overflowing lanes saturate (default wraps).
// ---------------------------------------------------------------------------
module mx_shift_rnd_lanes
  import mx_pkg::*;
#(
  parameter int LANES       = 4,
  parameter int WIDTH_I     = 9,
  parameter int WIDTH_O     = 8,
  parameter int WIDTH_SHIFT = $clog2(WIDTH_I + 2),
  parameter int WIDTH_CNT   = 16
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_valid,
  output logic                       o_ready,
  input  logic [LANES*WIDTH_I-1:0]   i_num,
  input  logic [WIDTH_SHIFT-1:0]     i_shift,
  input  logic [MODE_W-1:0]          i_mode,
  output logic                       o_valid,
  input  logic                       i_ready,
  output logic [LANES*WIDTH_O-1:0]   o_rnd,
  output logic [LANES-1:0]           o_ofl,
  input  logic                       i_cnt_clr,
  output logic [WIDTH_CNT-1:0]       o_ofl_cnt
);

  logic full1;
  logic full2;
  logic load;
  logic advance;
  logic xfer;
  logic counted;

  // Stage 2 can refill whenever it is empty or its beat leaves this cycle;
  // stage 1 stalls only when both stages hold beats and downstream blocks.
  assign o_ready = !(full2 && full1 && !i_ready);
  assign load    = i_valid && o_ready;
  assign advance = full1 && (!full2 || i_ready);
  assign o_valid = full2;
  assign xfer    = full2 && i_ready;
  assign counted = xfer && (|o_ofl);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      full1 <= 1'b0;
      full2 <= 1'b0;
    end else begin
      if (load) begin
        full1 <= 1'b1;
      end else if (advance) begin
        full1 <= 1'b0;
      end
      if (advance) begin
        full2 <= 1'b1;
      end else if (i_ready) begin
        full2 <= 1'b0;
      end
    end
  end

  // A clear wins over the old value but still counts a coincident
  // overflowing transfer; otherwise the count sticks at all-ones.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_ofl_cnt <= '0;
    end else if (i_cnt_clr) begin
      o_ofl_cnt <= counted ? WIDTH_CNT'(1) : '0;
    end else if (counted && (o_ofl_cnt != {WIDTH_CNT{1'b1}})) begin
      o_ofl_cnt <= o_ofl_cnt + WIDTH_CNT'(1);
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    shift_rnd_lane #(
      .WIDTH_I     (WIDTH_I),
      .WIDTH_O     (WIDTH_O),
      .WIDTH_SHIFT (WIDTH_SHIFT)
    ) u_lane (
      .clk     (i_clk),
      .rst_n   (i_rst_n),
      .load    (load),
      .advance (advance),
      .num     (i_num[l*WIDTH_I +: WIDTH_I]),
      .shift   (i_shift),
      .mode    (i_mode),
      .rnd     (o_rnd[l*WIDTH_O +: WIDTH_O]),
      .ofl     (o_ofl[l])
    );
  end

endmodule

// File: tb/tb_mx_shift_rnd_lanes.sv
// ---------------------------------------------------------------------------
// tb_mx_shift_rnd_lanes
// Directed and random stimulus for mx_shift_rnd_lanes (LANES=4, WIDTH_I=9,
// WIDTH_O=8, WIDTH_CNT=4). Expected results come from an exact-division
// reference model and an in-flight beat queue. Honours MX_SHIFT_RND_SAT_EN.
// ---------------------------------------------------------------------------
module tb_mx_shift_rnd_lanes;

  localparam int LANES = 4;
  localparam int WI    = 9;
  localparam int WO    = 8;
  localparam int WS    = 4;
  localparam int CW    = 4;
  localparam int CMAX  = (1 << CW) - 1;

  typedef struct {
    logic [31:0] rnd;
    logic [3:0]  ofl;
    int          acc;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid = 1'b0;
  logic [35:0] in_num = '0;
  logic [3:0]  in_shift = '0;
  logic [1:0]  in_mode = '0;
  logic        in_ready = 1'b0;
  logic        cnt_clr = 1'b0;
  logic        out_ready;
  logic        out_valid;
  logic [31:0] out_rnd;
  logic [3:0]  out_ofl;
  logic [3:0]  ofl_cnt;

  beat_t exp_q[$];
  int    cyc = 0;
  int    last_xfer = -10;
  int    cnt_model = 0;
  int    total = 0;
  int    bad = 0;

  always #5 clk = ~clk;

  mx_shift_rnd_lanes #(
    .LANES       (LANES),
    .WIDTH_I     (WI),
    .WIDTH_O     (WO),
    .WIDTH_SHIFT (WS),
    .WIDTH_CNT   (CW)
  ) dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_valid   (in_valid),
    .o_ready   (out_ready),
    .i_num     (in_num),
    .i_shift   (in_shift),
    .i_mode    (in_mode),
    .o_valid   (out_valid),
    .i_ready   (in_ready),
    .o_rnd     (out_rnd),
    .o_ofl     (out_ofl),
    .i_cnt_clr (cnt_clr),
    .o_ofl_cnt (ofl_cnt)
  );

  // Exact quotient x / 2^s rounded per mode, using integer division only.
  function automatic longint round_ref(input longint x, input int s, input int mode);
    longint d;
    longint qf;
    longint r;
    d  = longint'(1) << s;
    qf = x / d;
    if (x < 0 && qf * d != x) qf = qf - 1;
    r = x - qf * d;
    case (mode)
      1: return (x < 0 && r != 0) ? qf + 1 : qf;
      2: return qf;
      default: begin
        if (2 * r > d) return qf + 1;
        if (2 * r == d) return qf + (qf & 1);
        return qf;
      end
    endcase
  endfunction

  function automatic void model_beat(input logic [35:0] num, input int shift, input int mode,
                                     output logic [31:0] rnd, output logic [3:0] ofl);
    logic signed [8:0] e;
    longint x;
    longint v;
    rnd = '0;
    ofl = '0;
    for (int l = 0; l < LANES; l++) begin
      e = num[l*WI +: WI];
      x = e;
      v = round_ref(x, shift + (WI - WO), mode);
      ofl[l] = (v > 127) || (v < -128);
`ifdef MX_SHIFT_RND_SAT_EN
      if (v > 127) v = 127;
      else if (v < -128) v = -128;
`endif
      rnd[l*WO +: WO] = v[7:0];
    end
  endfunction

  function automatic logic [35:0] pack4(input int a, input int b, input int c, input int d);
    logic [35:0] r;
    r[8:0]   = a[8:0];
    r[17:9]  = b[8:0];
    r[26:18] = c[8:0];
    r[35:27] = d[8:0];
    return r;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, obs, expv, cyc);
    end
  endtask

  // One clock cycle: drive at the falling edge, check the outputs that the
  // model predicts for this cycle, then advance the model past the next
  // rising edge. A beat becomes visible two cycles after acceptance, but
  // never before the cycle after its predecessor left.
  task automatic applyStimulus(input logic v, input logic [35:0] num, input int shift,
                               input int mode, input logic rdy, input logic clr,
                               output logic accepted);
    logic        exp_rdy;
    logic        exp_vld;
    logic        xfer;
    logic        counted;
    int          vis;
    beat_t       b;
    in_valid = v;
    in_num   = num;
    in_shift = shift[3:0];
    in_mode  = mode[1:0];
    in_ready = rdy;
    cnt_clr  = clr;
    #1;
    exp_rdy = !(exp_q.size() == 2 && !rdy);
    exp_vld = 1'b0;
    if (exp_q.size() > 0) begin
      vis = exp_q[0].acc + 2;
      if (last_xfer + 1 > vis) vis = last_xfer + 1;
      exp_vld = (cyc >= vis);
    end
    checkOutput("o_ready", 32'(out_ready), 32'(exp_rdy));
    checkOutput("o_valid", 32'(out_valid), 32'(exp_vld));
    checkOutput("o_ofl_cnt", 32'(ofl_cnt), 32'(cnt_model));
    counted = 1'b0;
    xfer    = exp_vld && rdy;
    if (exp_vld) begin
      checkOutput("o_rnd", out_rnd, exp_q[0].rnd);
      checkOutput("o_ofl", 32'(out_ofl), 32'(exp_q[0].ofl));
      counted = xfer && (exp_q[0].ofl != 4'd0);
    end
    if (xfer) begin
      void'(exp_q.pop_front());
      last_xfer = cyc;
    end
    if (clr) cnt_model = counted ? 1 : 0;
    else if (counted && cnt_model < CMAX) cnt_model++;
    accepted = v && exp_rdy;
    if (accepted) begin
      model_beat(num, shift, mode, b.rnd, b.ofl);
      b.acc = cyc;
      exp_q.push_back(b);
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    logic acc;
    for (int i = 0; i < n; i++) applyStimulus(1'b0, '0, 0, 0, 1'b1, 1'b0, acc);
  endtask

  // Reset is asserted mid-cycle; outputs must clear without waiting a clock.
  task automatic doReset();
    rst_n    = 1'b0;
    in_valid = 1'b0;
    cnt_clr  = 1'b0;
    in_ready = 1'b1;
    #1;
    checkOutput("rst_o_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_o_rnd", out_rnd, 32'd0);
    checkOutput("rst_o_ofl", 32'(out_ofl), 32'd0);
    checkOutput("rst_o_ofl_cnt", 32'(ofl_cnt), 32'd0);
    checkOutput("rst_o_ready", 32'(out_ready), 32'd1);
    exp_q.delete();
    cnt_model = 0;
    last_xfer = cyc - 10;
    @(negedge clk);
    @(negedge clk);
    checkOutput("rst_hold_o_ready", 32'(out_ready), 32'd1);
    rst_n = 1'b1;
    cyc += 2;
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic acc;
    int   sent;
    logic [35:0] rn;
    @(negedge clk);
    doReset();

    $display("[TB] basic rounding, shift 0");
    for (int m = 0; m < 3; m++) applyStimulus(1'b1, pack4(3, 5, -3, -5), 0, m, 1'b1, 1'b0, acc);
    idle(4);

    $display("[TB] lane overflow");
    applyStimulus(1'b1, pack4(255, 0, 0, 0), 0, 0, 1'b1, 1'b0, acc);
    idle(4);

    $display("[TB] large shift of -1");
    for (int m = 0; m < 4; m++) applyStimulus(1'b1, pack4(-1, -1, -1, -1), 15, m, 1'b1, 1'b0, acc);
    idle(4);

    $display("[TB] 8-beat stream with backpressure");
    sent = 0;
    for (int k = 0; k < 14; k++) begin
      applyStimulus(sent < 8, pack4(sent * 37 - 100, 200 - sent * 29, -sent * 51, sent * 61),
                    sent % 4, sent % 4, !(k >= 3 && k <= 5), 1'b0, acc);
      if (acc) sent++;
    end
    idle(4);

    $display("[TB] clear coincident with counted transfer");
    applyStimulus(1'b1, pack4(255, 0, 0, 0), 0, 0, 1'b0, 1'b0, acc);
    applyStimulus(1'b0, '0, 0, 0, 1'b0, 1'b0, acc);
    applyStimulus(1'b0, '0, 0, 0, 1'b0, 1'b0, acc);
    applyStimulus(1'b0, '0, 0, 0, 1'b1, 1'b1, acc);
    idle(2);

    $display("[TB] counter saturation");
    for (int k = 0; k < 18; k++) applyStimulus(1'b1, pack4(255, -256, 255, 0), 0, 0, 1'b1, 1'b0, acc);
    idle(4);

    $display("[TB] reset with beats in flight");
    applyStimulus(1'b0, '0, 0, 0, 1'b1, 1'b1, acc);
    for (int k = 0; k < 5; k++) applyStimulus(1'b1, pack4(0, 255, 0, 0), 0, 0, 1'b1, 1'b0, acc);
    idle(3);
    applyStimulus(1'b1, pack4(10, 20, 30, 40), 0, 0, 1'b0, 1'b0, acc);
    applyStimulus(1'b1, pack4(-10, -20, -30, -40), 1, 1, 1'b0, 1'b0, acc);
    doReset();
    idle(5);

    $display("[TB] random traffic");
    for (int k = 0; k < 400; k++) begin
      rn = {$urandom_range(0, 15), $urandom()};
      applyStimulus($urandom_range(0, 3) != 0, rn, $urandom_range(0, 15), $urandom_range(0, 3),
                    $urandom_range(0, 3) != 0, $urandom_range(0, 31) == 0, acc);
    end
    idle(6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
